tube_driver: RTL and testbench

Eight-digit seven-segment tube controller on the I/O write path. It captures the 32-bit store data whenever the tube chip-select is asserted and drives a time-multiplexed, active-low 8-digit hex display on the board. It sits directly downstream of the memory/IO address decoder and consumes that decoder's tube chip-select, low address bits and write data.

---
 rtl/tube_driver.sv | 118 +++++++++++
 tb/tb_tube_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_driver.sv
// tube_driver: eight-digit, active-low, time-multiplexed hex display driver.
// Two registers are written from the I/O store path. Offset 0 holds the 32-bit
// value to show. Offset 4 holds the digit mask in bits [7:0] and the
// leading-zero suppress flag in bit [8]. A prescaler steps the lit digit every
// SCAN_DIV cycles. The pin outputs are registered from the current digit index
// and the current register contents.
module tube_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        TubeCtrl_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] write_data_i,
    output logic [7:0]  seg_en_o,
    output logic [7:0]  seg_out_o
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      value_q;
    logic [7:0]       mask_q;
    logic             lzs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       dig_q;

    logic [7:0]       seg_en_next;
    logic [7:0]       seg_out_next;
    logic [7:0]       upper_zero;
    logic [3:0]       nibble;
    logic             blank;

    // Bits 31:9 of a control write carry no meaning. They are folded here so
    // they stay visibly consumed.
    logic unused_wdata;
    assign unused_wdata = ^write_data_i[31:9];

    // Register writes from the decoder. Any offset other than 0 or 4 is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            value_q <= '0;
            mask_q  <= 8'hFF;
            lzs_q   <= 1'b0;
        end else if (TubeCtrl_i) begin
            if (addr_i == 4'h0) begin
                value_q <= write_data_i;
            end else if (addr_i == 4'h4) begin
                mask_q <= write_data_i[7:0];
                lzs_q  <= write_data_i[8];
            end
        end
    end

    // Scan prescaler and digit index. Writes never disturb these.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            dig_q <= dig_q + 3'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // upper_zero[i] is set when every nibble from digit i up to digit 7 is zero.
    // This flag marks digit i as a leading zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (value_q[31:4*gi] == '0);
        end
    endgenerate

    assign nibble = value_q[{dig_q, 2'b00} +: 4];
    assign blank  = ~mask_q[dig_q] | (lzs_q & (dig_q != 3'd0) & upper_zero[dig_q]);

    // Hex glyph lookup and digit enable for the current digit. dp stays off.
    always_comb begin
        seg_out_next = 8'hFF;
        seg_en_next  = 8'hFF;
        if (!blank) begin
            seg_en_next = ~(8'h01 << dig_q);
            case (nibble)
                4'h0: seg_out_next = 8'hC0;
                4'h1: seg_out_next = 8'hF9;
                4'h2: seg_out_next = 8'hA4;
                4'h3: seg_out_next = 8'hB0;
                4'h4: seg_out_next = 8'h99;
                4'h5: seg_out_next = 8'h92;
                4'h6: seg_out_next = 8'h82;
                4'h7: seg_out_next = 8'hF8;
                4'h8: seg_out_next = 8'h80;
                4'h9: seg_out_next = 8'h90;
                4'hA: seg_out_next = 8'h88;
                4'hB: seg_out_next = 8'h83;
                4'hC: seg_out_next = 8'hC6;
                4'hD: seg_out_next = 8'hA1;
                4'hE: seg_out_next = 8'h86;
                default: seg_out_next = 8'h8E;
            endcase
        end
    end

    // Registered pin drivers. They blank at once when reset is asserted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_en_o  <= 8'hFF;
            seg_out_o <= 8'hFF;
        end else begin
            seg_en_o  <= seg_en_next;
            seg_out_o <= seg_out_next;
        end
    end

endmodule

// File: tb/tb_tube_driver.sv
// tb_tube_driver: randomized and directed stimulus for tube_driver with
// SCAN_DIV=4. Each cycle is compared with a frame-level model of the display.
// The model keeps the register contents and the number of edges since reset.
// The lit digit is derived arithmetically as (edges / SCAN_DIV) mod 8.
module tb_tube_driver;

    localparam int SD = 4;

    logic        clk;
    logic        rst_n;
    logic        tube_ctrl;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    int checks   = 0;
    int failures = 0;

    tube_driver #(.SCAN_DIV(SD)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .TubeCtrl_i   (tube_ctrl),
        .addr_i       (addr),
        .write_data_i (wdata),
        .seg_en_o     (seg_en),
        .seg_out_o    (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_value;
    logic [7:0]  m_mask;
    logic        m_lzs;
    int          m_edges;
    logic [7:0]  exp_en;
    logic [7:0]  exp_seg;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;
            4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
            4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic is_blank(input logic [31:0] v, input logic [7:0] m,
                                      input logic lz, input int d);
        logic [31:0] upper;
        upper = v >> (4 * d);
        return (m[d] == 1'b0) || (lz && d != 0 && upper == 32'd0);
    endfunction

    function automatic logic [7:0] model_en(input logic [31:0] v, input logic [7:0] m,
                                            input logic lz, input int d);
        logic [7:0] onehot;
        onehot = 8'h01 << d;
        return is_blank(v, m, lz, d) ? 8'hFF : ~onehot;
    endfunction

    function automatic logic [7:0] model_seg(input logic [31:0] v, input logic [7:0] m,
                                             input logic lz, input int d);
        logic [31:0] upper;
        upper = v >> (4 * d);
        return is_blank(v, m, lz, d) ? 8'hFF : glyph(upper[3:0]);
    endfunction

    // Model update: the pins show the digit and registers as they stood before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_value <= 32'd0;
            m_mask  <= 8'hFF;
            m_lzs   <= 1'b0;
            m_edges <= 0;
            exp_en  <= 8'hFF;
            exp_seg <= 8'hFF;
        end else begin
            exp_en  <= model_en(m_value, m_mask, m_lzs, (m_edges / SD) % 8);
            exp_seg <= model_seg(m_value, m_mask, m_lzs, (m_edges / SD) % 8);
            m_edges <= m_edges + 1;
            if (tube_ctrl && addr == 4'h0) m_value <= wdata;
            if (tube_ctrl && addr == 4'h4) begin
                m_mask <= wdata[7:0];
                m_lzs  <= wdata[8];
            end
        end
    end

    // Drive one write for a single edge. Must be called right after a negedge.
    task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
        tube_ctrl = 1'b1;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        tube_ctrl = 1'b0;
        addr      = 4'($urandom_range(0, 15));
        wdata     = $urandom;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tube_ctrl = 1'b0;
        addr = 4'h0;
        wdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tube_ctrl = ~tube_ctrl;
            addr      = (i == 1) ? 4'h4 : 4'h0;
            wdata     = $urandom;
            checks++;
            if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d en=%h seg=%h want FF/FF", i, seg_en, seg_out);
            end
        end
        @(negedge clk);
        tube_ctrl = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
            failures++;
            $display("FAIL reset_release en=%h seg=%h want FE/C0", seg_en, seg_out);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_value_write;
        drive_write(4'h0, 32'h12345678);
        for (int i = 0; i < 8 * SD + 6; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL value_frame cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
        end
        $display("test_value_write done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mask;
        drive_write(4'h0, 32'hFFFFFFFF);
        drive_write(4'h4, 32'h0000000F);
        for (int i = 0; i < 8 * SD + 2; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL mask_frame cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
            checks++;
            if (!(seg_en == 8'hFF && seg_out == 8'hFF) && seg_out !== 8'h8E) begin
                failures++;
                $display("FAIL mask_glyph cyc=%0d seg=%h want 8E or blank", i, seg_out);
            end
        end
        $display("test_mask done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_lzs;
        drive_write(4'h4, 32'h00000100);
        drive_write(4'h0, 32'h000000A0);
        for (int i = 0; i < 8 * SD + 2; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL lzs_a0 cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
        end
        drive_write(4'h0, 32'h00000000);
        for (int i = 0; i < 8 * SD + 2; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL lzs_zero cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
            checks++;
            if (!(seg_en == 8'hFF && seg_out == 8'hFF) && !(seg_en == 8'hFE && seg_out == 8'hC0)) begin
                failures++;
                $display("FAIL lzs_zero_only_d0 cyc=%0d en=%h seg=%h want FE/C0 or blank", i, seg_en, seg_out);
            end
        end
        $display("test_lzs done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_boundary;
        int   d_prev;
        bit   found;
        logic [7:0] want_en;
        drive_write(4'h4, 32'h000000FF);
        drive_write(4'h0, 32'h00000000);
        found = 1'b0;
        for (int i = 0; i < 4 * SD && !found; i++) begin
            if (m_edges % SD == SD - 1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL boundary_wait timeout edges=%0d want wrap point", m_edges);
        end else begin
            d_prev = (m_edges / SD) % 8;
            drive_write(4'h0, 32'hFFFFFFFF);
            checks++;
            if (seg_out !== 8'hC0) begin
                failures++;
                $display("FAIL boundary_old seg=%h want C0", seg_out);
            end
            want_en = ~(8'h01 << ((d_prev + 1) % 8));
            for (int i = 0; i < SD; i++) begin
                @(negedge clk);
                checks++;
                if (seg_en !== want_en || seg_out !== 8'h8E) begin
                    failures++;
                    $display("FAIL boundary_dwell cyc=%0d en=%h seg=%h want %h/8E", i, seg_en, seg_out, want_en);
                end
            end
            @(negedge clk);
            checks++;
            if (seg_en === want_en) begin
                failures++;
                $display("FAIL boundary_advance en=%h want not %h", seg_en, want_en);
            end
        end
        $display("test_boundary done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back;
        tube_ctrl = 1'b1;
        addr = 4'h0;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        wdata = 32'h0BADC0DE;
        @(negedge clk);
        tube_ctrl = 1'b0;
        for (int i = 0; i < 8 * SD + 2; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL b2b_frame cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
        end
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL random cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
            checks++;
            if (seg_en !== 8'hFF && $countones(~seg_en) != 1) begin
                failures++;
                $display("FAIL onehot cyc=%0d en=%h want one low bit", i, seg_en);
            end
            tube_ctrl = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1: addr = 4'h0;
                2:    addr = 4'h4;
                default: addr = 4'($urandom_range(0, 15));
            endcase
            wdata = $urandom;
            if (addr == 4'h4) wdata[7:0] = wdata[7:0] | 8'h81;
        end
        tube_ctrl = 1'b0;
        $display("test_random done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_async_reset;
        bit found;
        drive_write(4'h4, 32'h000000FF);
        drive_write(4'h0, 32'h87654321);
        found = 1'b0;
        for (int i = 0; i < 10 * SD && !found; i++) begin
            @(negedge clk);
            if (seg_en == 8'hDF) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL async_wait_d5 en=%h want DF within budget", seg_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
            failures++;
            $display("FAIL async_blank en=%h seg=%h want FF/FF", seg_en, seg_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8 * SD + 2; i++) begin
            @(negedge clk);
            checks++;
            if (seg_en !== exp_en || seg_out !== exp_seg) begin
                failures++;
                $display("FAIL async_frame cyc=%0d en=%h seg=%h want %h/%h", i, seg_en, seg_out, exp_en, exp_seg);
            end
            checks++;
            if (seg_out !== 8'hC0 || seg_en === 8'hFF) begin
                failures++;
                $display("FAIL async_defaults cyc=%0d en=%h seg=%h want lit C0", i, seg_en, seg_out);
            end
        end
        checks++;
        if (i_first_digit_ok() == 1'b0) begin
            failures++;
            $display("FAIL async_restart en=%h want FE at frame start", seg_en);
        end
        $display("test_async_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    // After 8*SD+2 cycles from release, the pins sit in digit 0's dwell again.
    function automatic logic i_first_digit_ok;
        return (seg_en == 8'hFE);
    endfunction

    initial begin
        test_reset;
        test_value_write;
        test_mask;
        test_lzs;
        test_boundary;
        test_back_to_back;
        test_random;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
